ps2_cursor_ctrl: RTL and testbench

Parametrised successor to the keyboard coordinate/action decoders. It consumes PS/2 scancode bytes and tracks make/break and extended (E0) prefixes with a state machine. It maintains an (x, y) cursor on a GRID_W x GRID_H board, with wrap or clamp at the edges, and emits one-cycle action pulses for enter and quit. It sits between the PS/2 receiver and the game-board logic.

---
 rtl/ps2_cursor_ctrl_if.sv | 19 +
 rtl/ps2_cursor_ctrl.sv | 103 ++++++++++
 tb/tb_ps2_cursor_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ps2_cursor_ctrl_if.sv
// ps2_cursor_ctrl_if: scancode byte stream in, cursor position and action pulses out.
interface ps2_cursor_ctrl_if #(
  parameter int GRID_W = 5,
  parameter int GRID_H = 5
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  logic [7:0]    d;
  logic          en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          moved;
  logic          enter;
  logic          quit;
  logic [5:0]    key_held;
  logic          err;
  modport master (output d, en, input x, y, moved, enter, quit, key_held, err);
  modport slave (input d, en, output x, y, moved, enter, quit, key_held, err);
endinterface

// File: rtl/ps2_cursor_ctrl.sv
// ps2_cursor_ctrl: PS/2 scancode decoder driving a wrapping/clamping grid cursor.
// Optional macro REPEAT_FILTER_EN suppresses typematic repeats of an already-held key.
module ps2_cursor_ctrl #(
  parameter int GRID_W = 5,
  parameter int GRID_H = 5,
  parameter bit WRAP   = 1'b1
) (
  input logic             clk,
  input logic             reset,
  ps2_cursor_ctrl_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;
  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_dec, x_inc;
  logic [YW-1:0] y_q, y_d, y_dec, y_inc;
  logic [5:0]    held_q, held_d, key_sel;
  logic          moved_q, moved_d, enter_q, enter_d, quit_q, quit_d, err_q, err_d;
  logic          is_e0, is_f0, is_pfx, ext, make, brk, act;
  assign is_e0  = bus.d == 8'hE0;
  assign is_f0  = bus.d == 8'hF0;
  assign is_pfx = is_e0 || is_f0;
  assign ext    = state_q == EXT || state_q == EXT_BRK;
  // bit order {quit, enter, right, left, down, up}; quit exists only in plain form
  assign key_sel = {bus.d == 8'h15 && !ext, bus.d == 8'h5A, bus.d == 8'h74,
                    bus.d == 8'h6B, bus.d == 8'h72, bus.d == 8'h75};
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    make    = 1'b0;
    brk     = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (is_e0) state_d = EXT;
          else if (is_f0) state_d = BRK;
          else make = 1'b1;
        end
        EXT: begin
          if (is_f0) state_d = EXT_BRK;
          else if (is_e0) err_d = 1'b1;
          else begin
            make    = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          err_d   = is_pfx;
          brk     = !is_pfx;
        end
      endcase
    end
  end
`ifdef REPEAT_FILTER_EN
  assign act = make && !(|(key_sel & held_q));
`else
  assign act = make;
`endif
  always_comb begin
    x_dec   = x_q == '0 ? (WRAP ? XMAX : '0) : x_q - XW'(1);
    x_inc   = x_q == XMAX ? (WRAP ? '0 : XMAX) : x_q + XW'(1);
    y_dec   = y_q == '0 ? (WRAP ? YMAX : '0) : y_q - YW'(1);
    y_inc   = y_q == YMAX ? (WRAP ? '0 : YMAX) : y_q + YW'(1);
    x_d     = act && key_sel[2] ? x_dec : act && key_sel[3] ? x_inc : x_q;
    y_d     = act && key_sel[0] ? y_dec : act && key_sel[1] ? y_inc : y_q;
    held_d  = make ? held_q | key_sel : brk ? held_q & ~key_sel : held_q;
    moved_d = x_d != x_q || y_d != y_q;
    enter_d = act && key_sel[4];
    quit_d  = act && key_sel[5];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      held_q  <= '0;
      moved_q <= 1'b0;
      enter_q <= 1'b0;
      quit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      held_q  <= held_d;
      moved_q <= moved_d;
      enter_q <= enter_d;
      quit_q  <= quit_d;
      err_q   <= err_d;
    end
  end
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.key_held = held_q;
  assign bus.moved    = moved_q;
  assign bus.enter    = enter_q;
  assign bus.quit     = quit_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// tb_ps2_cursor_ctrl: scoreboard bench driving a wrapping 5x5 and a clamping 5x3 instance.
module tb_ps2_cursor_ctrl;
  typedef struct {
    int       x;
    int       y;
    bit       moved;
    bit       enter;
    bit       quit;
    bit       err;
    bit [5:0] held;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   gw[2] = '{5, 5};
  int   gh[2] = '{5, 3};
  bit   gwrap[2] = '{1'b1, 1'b0};
  int   mx[2], my[2];
  bit [5:0] mh[2];
  bit   pe0, pf0;
  always #5 clk = ~clk;
  ps2_cursor_ctrl_if #(.GRID_W(5), .GRID_H(5)) bus0 ();
  ps2_cursor_ctrl_if #(.GRID_W(5), .GRID_H(3)) bus1 ();
  ps2_cursor_ctrl #(.GRID_W(5), .GRID_H(5), .WRAP(1'b1)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
  ps2_cursor_ctrl #(.GRID_W(5), .GRID_H(3), .WRAP(1'b0)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
  function automatic int key_index(byte d, bit ext);
    case (d)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      8'h5A: return 4;
      8'h15: return ext ? -1 : 5;
      default: return -1;
    endcase
  endfunction
  function automatic int move(int v, int dir, int n, bit wrap);
    if (wrap) return (v + dir + n) % n;
    if (v + dir < 0) return 0;
    if (v + dir > n - 1) return n - 1;
    return v + dir;
  endfunction
  task automatic step(bit r, bit e, byte d);
    bit ev, ext, is_brk, err;
    int idx;
    exp_t ex[2];
    @(negedge clk);
    rst = r;
    bus0.en = e; bus0.d = d;
    bus1.en = e; bus1.d = d;
    ev = 0; ext = 0; is_brk = 0; err = 0;
    if (r) begin
      pe0 = 0; pf0 = 0;
      for (int k = 0; k < 2; k++) begin mx[k] = 0; my[k] = 0; mh[k] = '0; end
    end else if (e) begin
      if (d == 8'hE0) begin
        if (pf0) begin err = 1; pe0 = 0; pf0 = 0; end
        else if (pe0) err = 1;
        else pe0 = 1;
      end else if (d == 8'hF0) begin
        if (pf0) begin err = 1; pe0 = 0; pf0 = 0; end
        else pf0 = 1;
      end else begin
        ev = 1; ext = pe0; is_brk = pf0; pe0 = 0; pf0 = 0;
      end
    end
    idx = key_index(d, ext);
    for (int k = 0; k < 2; k++) begin
      ex[k] = '{x: mx[k], y: my[k], moved: 0, enter: 0, quit: 0, err: err, held: '0};
      if (ev && idx >= 0) begin
        if (is_brk) mh[k][idx] = 1'b0;
        else begin
          bit acts = 1'b1;
`ifdef REPEAT_FILTER_EN
          acts = !mh[k][idx];
`endif
          mh[k][idx] = 1'b1;
          if (acts) begin
            int nx = mx[k], ny = my[k];
            if (idx == 0) ny = move(my[k], -1, gh[k], gwrap[k]);
            if (idx == 1) ny = move(my[k], 1, gh[k], gwrap[k]);
            if (idx == 2) nx = move(mx[k], -1, gw[k], gwrap[k]);
            if (idx == 3) nx = move(mx[k], 1, gw[k], gwrap[k]);
            ex[k].moved = nx != mx[k] || ny != my[k];
            ex[k].enter = idx == 4;
            ex[k].quit  = idx == 5;
            mx[k] = nx; my[k] = ny;
          end
        end
      end
      ex[k].x = mx[k]; ex[k].y = my[k]; ex[k].held = mh[k];
    end
    q0.push_back(ex[0]);
    q1.push_back(ex[1]);
  endtask
  task automatic send(byte d); step(1'b0, 1'b1, d); endtask
  task automatic idle(); step(1'b0, 1'b0, 8'($urandom)); endtask
  task automatic reset_cycle(); step(1'b1, 1'($urandom), 8'hE0); endtask
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0.x", int'(bus0.x), e.x);
      chk("d0.y", int'(bus0.y), e.y);
      chk("d0.moved", int'(bus0.moved), int'(e.moved));
      chk("d0.enter", int'(bus0.enter), int'(e.enter));
      chk("d0.quit", int'(bus0.quit), int'(e.quit));
      chk("d0.err", int'(bus0.err), int'(e.err));
      chk("d0.held", int'(bus0.key_held), int'(e.held));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1.x", int'(bus1.x), e.x);
      chk("d1.y", int'(bus1.y), e.y);
      chk("d1.moved", int'(bus1.moved), int'(e.moved));
      chk("d1.enter", int'(bus1.enter), int'(e.enter));
      chk("d1.quit", int'(bus1.quit), int'(e.quit));
      chk("d1.err", int'(bus1.err), int'(e.err));
      chk("d1.held", int'(bus1.key_held), int'(e.held));
    end
  end
  initial begin
    byte pool[9] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h15, 8'h00};
    bus0.en = 0; bus0.d = 0; bus1.en = 0; bus1.d = 0;
    reset_cycle(); reset_cycle();
    repeat (3) begin send(8'hE0); send(8'h74); idle(); end
    reset_cycle();
    send(8'hE0); send(8'h6B); send(8'h74);
    repeat (5) send(8'h74);
    send(8'hF0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h72);
    send(8'h5A); idle(); send(8'hF0); send(8'h5A); send(8'h15); send(8'hF0); send(8'h15);
    send(8'hE0); send(8'hE0); send(8'h75); send(8'hF0); send(8'hF0); send(8'h75);
    send(8'hE0); reset_cycle(); send(8'h75);
    reset_cycle();
    send(8'h75); send(8'h75); send(8'h75); send(8'hF0); send(8'h75); send(8'h75);
    repeat (3000) begin
      if ($urandom_range(199) == 0) reset_cycle();
      else if ($urandom_range(3) == 0) idle();
      else begin
        byte b = pool[$urandom_range(8)];
        if (b == 8'h00) b = 8'($urandom);
        send(b);
      end
    end
    idle();
    repeat (4) @(posedge clk);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
